// File: rtl/tdm_slot_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_pkg
//  Brief    : Shared types and helpers for the TDM slot multiplexer.
//  Revision : 1.0  initial release
// ============================================================================
package tdm_pkg;

  // FSM states of the slot multiplexer
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest one-hot vector the helper can build
  localparam int MAX_CH = 32;

  // Counter width for a counter that runs 0..n-1; never narrower than 1 bit
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One-hot of idx; all zeros when idx falls outside 0..n-1
  function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_CH-1:0] r;
    r = '0;
    if (idx < n) r = MAX_CH'(1) << idx;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_code_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_code_decoder
//  Brief    : Binary channel code to one-hot selection plus invalid flag.
//             Code 0 selects nothing; codes above CH_COUNT flag invalid.
//             Purely combinational, the parent registers the results.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_code_decoder
  import tdm_pkg::*;
#(
  parameter int CH_COUNT = 3,
  parameter int SEL_W    = 2
) (
  input  logic [SEL_W-1:0]    code,
  output logic [CH_COUNT-1:0] sel,
  output logic                invalid
);

  localparam logic [SEL_W-1:0] CH_MAX = SEL_W'(CH_COUNT);

  // Decode 1..CH_COUNT to channel code-1; anything else selects nothing
  always_comb begin
    sel     = '0;
    invalid = (code > CH_MAX);
    if ((code != '0) && (code <= CH_MAX)) begin
      sel = CH_COUNT'(onehot(32'(code) - 32'd1, CH_COUNT));
    end
  end

endmodule
`default_nettype wire

// File: rtl/tdm_slot_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_slot_mux
//  Brief    : Time-division slot multiplexer. A channel code is captured once
//             per frame; an internal slot counter rotates through CH_COUNT
//             phases of SLOT_CYCLES cycles; q passes the selected channel's
//             data bit only during its own slot.
//  Config   : TDM_SLOT_SKIP_EN - unselected slots shrink to a single cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_slot_mux
  import tdm_pkg::*;
#(
  parameter int CH_COUNT    = 3,
  parameter int SEL_W       = 2,
  parameter int SLOT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SEL_W-1:0]    code,
  input  logic [CH_COUNT-1:0] ch_data,
  output logic [CH_COUNT-1:0] phase,
  output logic [CH_COUNT-1:0] sel_onehot,
  output logic                q,
  output logic                frame_done,
  output logic                code_err
);

  localparam int CW = cnt_w(SLOT_CYCLES);
  localparam int SW = cnt_w(CH_COUNT);
  localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(CH_COUNT - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cyc_cnt, cyc_nx;
  logic [SW-1:0]     slot_idx, slot_nx;
  logic [SEL_W-1:0]  code_q, code_nx;
  logic              capture;
  logic              slot_end;
  logic [CH_COUNT-1:0] dec_sel;
  logic              dec_invalid;

  // Slot length: fixed, or one cycle for slots that carry no selection
`ifdef TDM_SLOT_SKIP_EN
  assign slot_end = (|(phase & sel_onehot)) ? (cyc_cnt == CYC_LAST) : 1'b1;
`else
  assign slot_end = (cyc_cnt == CYC_LAST);
`endif

  assign frame_done = (state == RUN) && slot_end && (slot_idx == SLOT_LAST);
  assign phase      = (state == RUN) ? CH_COUNT'(onehot(32'(slot_idx), CH_COUNT)) : '0;

  // Decoding the next code_q value keeps sel_onehot aligned with the capture edge
  tdm_code_decoder #(
    .CH_COUNT (CH_COUNT),
    .SEL_W    (SEL_W)
  ) u_dec (
    .code    (code_nx),
    .sel     (dec_sel),
    .invalid (dec_invalid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, counters and code capture; en and code only matter at frame boundaries
  always_comb begin
    state_nx = state;
    cyc_nx   = cyc_cnt;
    slot_nx  = slot_idx;
    code_nx  = code_q;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nx = RUN;
          capture  = 1'b1;
          cyc_nx   = '0;
          slot_nx  = '0;
        end
      end
      RUN: begin
        if (frame_done) begin
          cyc_nx  = '0;
          slot_nx = '0;
          if (en) capture  = 1'b1;
          else    state_nx = IDLE;
        end else if (slot_end) begin
          cyc_nx  = '0;
          slot_nx = slot_idx + SW'(1);
        end else begin
          cyc_nx  = cyc_cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    if (capture) code_nx = code;
  end

  // Datapath registers: counters, captured code, decode, error pulse and output
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt    <= '0;
      slot_idx   <= '0;
      code_q     <= '0;
      sel_onehot <= '0;
      code_err   <= 1'b0;
      q          <= 1'b0;
    end else begin
      cyc_cnt    <= cyc_nx;
      slot_idx   <= slot_nx;
      code_q     <= code_nx;
      sel_onehot <= dec_sel;
      code_err   <= capture & dec_invalid;
      q          <= |(sel_onehot & phase & ch_data);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_slot_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_slot_mux
//  Brief    : Randomised self-checking bench for tdm_slot_mux. Runs a
//             3-channel and a 2-channel instance side by side against a
//             frame-position reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_slot_mux;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] code;
  logic [2:0] ch_data;

  logic [2:0] phase_a, sel_a;
  logic       q_a, fd_a, err_a;
  logic [1:0] phase_b, sel_b;
  logic       q_b, fd_b, err_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdm_slot_mux #(.CH_COUNT(3), .SEL_W(2), .SLOT_CYCLES(SC)) dut_a (
    .clk(clk), .rst(rst), .en(en), .code(code), .ch_data(ch_data),
    .phase(phase_a), .sel_onehot(sel_a), .q(q_a), .frame_done(fd_a), .code_err(err_a)
  );

  tdm_slot_mux #(.CH_COUNT(2), .SEL_W(2), .SLOT_CYCLES(SC)) dut_b (
    .clk(clk), .rst(rst), .en(en), .code(code), .ch_data(ch_data[1:0]),
    .phase(phase_b), .sel_onehot(sel_b), .q(q_b), .frame_done(fd_b), .code_err(err_b)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: position t inside the current frame plus the captured code
  typedef struct {
    bit run;
    int code;
    int t;
    bit q;
    bit err;
  } m_t;

  m_t ma, mb;

  function automatic int sel_idx(int n, int c);
    return (c >= 1 && c <= n) ? c - 1 : -1;
  endfunction

  function automatic int dur(int n, int c, int k);
`ifdef TDM_SLOT_SKIP_EN
    return (k == sel_idx(n, c)) ? SC : 1;
`else
    return SC;
`endif
  endfunction

  function automatic int frame_len(int n, int c);
    int s = 0;
    for (int k = 0; k < n; k++) s += dur(n, c, k);
    return s;
  endfunction

  function automatic int slot_of(int n, int c, int t);
    int acc = 0;
    for (int k = 0; k < n; k++) begin
      acc += dur(n, c, k);
      if (t < acc) return k;
    end
    return n - 1;
  endfunction

  function automatic int m_phase(m_t m, int n);
    return m.run ? (1 << slot_of(n, m.code, m.t)) : 0;
  endfunction

  function automatic int m_sel(m_t m, int n);
    int s = sel_idx(n, m.code);
    return (s >= 0) ? (1 << s) : 0;
  endfunction

  function automatic bit m_fd(m_t m, int n);
    return m.run && (m.t == frame_len(n, m.code) - 1);
  endfunction

  function automatic m_t step(m_t m, int n, bit r, bit e, int c, int d);
    m_t x = m;
    if (r) begin
      x.run = 0; x.code = 0; x.t = 0; x.q = 0; x.err = 0;
      return x;
    end
    x.q   = ((m_sel(m, n) & m_phase(m, n) & d) != 0);
    x.err = 0;
    if (!m.run) begin
      if (e) begin
        x.run = 1; x.t = 0; x.code = c; x.err = (c > n);
      end
    end else if (m.t == frame_len(n, m.code) - 1) begin
      x.t = 0;
      if (e) begin
        x.code = c; x.err = (c > n);
      end else begin
        x.run = 0;
      end
    end else begin
      x.t = m.t + 1;
    end
    return x;
  endfunction

  task automatic compare_all();
    check("a_phase", {5'b0, phase_a}, 8'(m_phase(ma, 3)));
    check("a_sel",   {5'b0, sel_a},   8'(m_sel(ma, 3)));
    check("a_q",     {7'b0, q_a},     {7'b0, ma.q});
    check("a_fdone", {7'b0, fd_a},    {7'b0, m_fd(ma, 3)});
    check("a_err",   {7'b0, err_a},   {7'b0, ma.err});
    check("b_phase", {6'b0, phase_b}, 8'(m_phase(mb, 2)));
    check("b_sel",   {6'b0, sel_b},   8'(m_sel(mb, 2)));
    check("b_q",     {7'b0, q_b},     {7'b0, mb.q});
    check("b_fdone", {7'b0, fd_b},    {7'b0, m_fd(mb, 2)});
    check("b_err",   {7'b0, err_b},   {7'b0, mb.err});
  endtask

  // Drive one cycle of inputs, advance the model over the edge, sample at negedge
  task automatic tick(input bit r, input bit e, input int c, input int d);
    rst     = r;
    en      = e;
    code    = 2'(c);
    ch_data = 3'(d);
    ma = step(ma, 3, r, e, c, d);
    mb = step(mb, 2, r, e, c, d & 3);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    ma = '{run: 0, code: 0, t: 0, q: 0, err: 0};
    mb = ma;
    rst = 1'b1; en = 1'b1; code = 2'd1; ch_data = 3'b000;

    // Reset held with en high: everything stays quiet
    repeat (2) tick(1, 1, 1, 0);

    // Basic frame on channel 2, then a mid-frame code change to 1
    repeat (5)  tick(0, 1, 2, 3'b010);
    repeat (20) tick(0, 1, 1, 3'b011);

    // Null code, then code 3 (invalid for the 2-channel instance)
    repeat (14) tick(0, 1, 0, 3'b111);
    repeat (26) tick(0, 1, 3, 3'b111);

    // Reset mid-frame with en held high
    repeat (6)  tick(0, 1, 2, 3'b010);
    tick(1, 1, 2, 3'b010);
    repeat (8)  tick(0, 1, 2, 3'b010);

    // en dropped mid-frame: frame completes, then idle
    repeat (20) tick(0, 0, 2, 3'b010);

    // Randomised traffic with occasional resets and idle stretches
    for (int i = 0; i < 900; i++) begin
      tick(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
